// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter for a single memory port with a burst limit.
// Memory read data is combinational, so read data is registered per port on the grant edge.
module mem_bus_arbiter #(
    parameter int AW        = 16,
    parameter int DW        = 16,
    parameter int MAX_BURST = 8
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_m0_req,
    input  logic [AW-1:0] i_m0_address,
    input  logic [DW-1:0] i_m0_data_out,
    input  logic          i_m0_wren_n,
    output logic          o_m0_gnt,
    output logic [DW-1:0] o_m0_data_in,
    output logic          o_m0_valid,
    input  logic          i_m1_req,
    input  logic [AW-1:0] i_m1_address,
    input  logic [DW-1:0] i_m1_data_out,
    input  logic          i_m1_wren_n,
    output logic          o_m1_gnt,
    output logic [DW-1:0] o_m1_data_in,
    output logic          o_m1_valid,
    output logic [AW-1:0] o_mem_address,
    output logic [DW-1:0] o_mem_data_out,
    output logic          o_mem_wren_n,
    input  logic [DW-1:0] i_mem_data_in
);
    localparam int            CW   = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] BMAX = CW'(MAX_BURST - 1);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t        r_state, w_next;
    logic          r_last;
    logic [CW-1:0] r_burst;
    logic          w_gnt0, w_gnt1;

    assign w_gnt0   = (r_state == OWN0) && i_m0_req;
    assign w_gnt1   = (r_state == OWN1) && i_m1_req;
    assign o_m0_gnt = w_gnt0;
    assign o_m1_gnt = w_gnt1;

    // Memory port is driven only while a grant is live, so no stray writes.
    always_comb begin
        o_mem_address  = '0;
        o_mem_data_out = '0;
        o_mem_wren_n   = 1'b1;
        if (w_gnt0) begin
            o_mem_address  = i_m0_address;
            o_mem_data_out = i_m0_data_out;
            o_mem_wren_n   = i_m0_wren_n;
        end else if (w_gnt1) begin
            o_mem_address  = i_m1_address;
            o_mem_data_out = i_m1_data_out;
            o_mem_wren_n   = i_m1_wren_n;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (i_m0_req && i_m1_req) w_next = r_last ? OWN0 : OWN1;
                else if (i_m0_req)        w_next = OWN0;
                else if (i_m1_req)        w_next = OWN1;
                else                      w_next = IDLE;
            end
            OWN0: begin
                if (i_m0_req && (!i_m1_req || r_burst < BMAX)) w_next = OWN0;
                else if (i_m1_req)                             w_next = OWN1;
                else                                           w_next = IDLE;
            end
            OWN1: begin
                if (i_m1_req && (!i_m0_req || r_burst < BMAX)) w_next = OWN1;
                else if (i_m0_req)                             w_next = OWN0;
                else                                           w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= IDLE;
            r_last       <= 1'b1;
            r_burst      <= '0;
            o_m0_valid   <= 1'b0;
            o_m1_valid   <= 1'b0;
            o_m0_data_in <= '0;
            o_m1_data_in <= '0;
        end else begin
            r_state <= w_next;
            // Counter restarts on any change of owner, including a drop to IDLE.
            if (w_next != r_state || w_next == IDLE)
                r_burst <= '0;
            else if ((w_gnt0 || w_gnt1) && r_burst != BMAX)
                r_burst <= r_burst + CW'(1);
            if (w_gnt0) r_last <= 1'b0;
            else if (w_gnt1) r_last <= 1'b1;
            o_m0_valid <= w_gnt0 && i_m0_wren_n;
            o_m1_valid <= w_gnt1 && i_m1_wren_n;
            if (w_gnt0 && i_m0_wren_n) o_m0_data_in <= i_mem_data_in;
            if (w_gnt1 && i_m1_wren_n) o_m1_data_in <= i_mem_data_in;
        end
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench: u_dut uses MAX_BURST=8, u_dut1 shares the inputs with MAX_BURST=1.
module tb_mem_bus_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m0_req = 0, m0_wren_n = 1, m1_req = 0, m1_wren_n = 1;
    logic [15:0] m0_addr = 0, m0_dout = 0, m1_addr = 0, m1_dout = 0;

    logic        g0, g1, v0, v1, wr;
    logic [15:0] d0, d1, maddr, mdout, mdin;
    logic        h_g0, h_g1, h_v0, h_v1, h_wr;
    logic [15:0] h_d0, h_d1, h_maddr, h_mdout, h_mdin;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Memory model: fixed value at address 3, otherwise a simple address pattern.
    assign mdin   = (maddr == 16'd3)   ? 16'h4000 : (maddr ^ 16'h5A5A);
    assign h_mdin = (h_maddr == 16'd3) ? 16'h4000 : (h_maddr ^ 16'h5A5A);

    mem_bus_arbiter #(.AW(16), .DW(16), .MAX_BURST(8)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_m0_req(m0_req), .i_m0_address(m0_addr), .i_m0_data_out(m0_dout), .i_m0_wren_n(m0_wren_n),
        .o_m0_gnt(g0), .o_m0_data_in(d0), .o_m0_valid(v0),
        .i_m1_req(m1_req), .i_m1_address(m1_addr), .i_m1_data_out(m1_dout), .i_m1_wren_n(m1_wren_n),
        .o_m1_gnt(g1), .o_m1_data_in(d1), .o_m1_valid(v1),
        .o_mem_address(maddr), .o_mem_data_out(mdout), .o_mem_wren_n(wr), .i_mem_data_in(mdin)
    );

    mem_bus_arbiter #(.AW(16), .DW(16), .MAX_BURST(1)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_m0_req(m0_req), .i_m0_address(m0_addr), .i_m0_data_out(m0_dout), .i_m0_wren_n(m0_wren_n),
        .o_m0_gnt(h_g0), .o_m0_data_in(h_d0), .o_m0_valid(h_v0),
        .i_m1_req(m1_req), .i_m1_address(m1_addr), .i_m1_data_out(m1_dout), .i_m1_wren_n(m1_wren_n),
        .o_m1_gnt(h_g1), .o_m1_data_in(h_d1), .o_m1_valid(h_v1),
        .o_mem_address(h_maddr), .o_mem_data_out(h_mdout), .o_mem_wren_n(h_wr), .i_mem_data_in(h_mdin)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // 1: reset asserted in the middle of a port-0 write
        #12 rst_n = 1'b1;
        tick();
        chk("rst_d0", d0, 16'h0);
        chk("rst_v0", v0, 0);
        m0_req = 1; m0_wren_n = 0; m0_addr = 16'h0005; m0_dout = 16'h1234;
        tick();
        chk("wr_gnt0", g0, 1);
        chk("wr_en", wr, 0);
        chk("wr_addr", maddr, 16'h0005);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_wren", wr, 1);
        chk("arst_gnt", {g0, g1}, 2'b00);
        chk("arst_valid", {v0, v1}, 2'b00);
        m0_req = 0; m0_wren_n = 1; m0_addr = 0; m0_dout = 0;
        #2 rst_n = 1'b1;
        tick();
        chk("post_rst_idle", {g0, g1, wr}, 3'b001);

        // 3/4: tie from reset, both held; burst 8 on u_dut, alternation on u_dut1
        m0_req = 1; m1_req = 1; m0_addr = 16'h0020; m1_addr = 16'h0030;
        chk("tie_arb_cycle", {g0, g1}, 2'b00);
        for (int i = 0; i < 32; i++) begin
            tick();
            chk($sformatf("b8_%0d", i), {g0, g1}, ((i / 8) % 2 == 0) ? 2'b10 : 2'b01);
            chk($sformatf("b1_%0d", i), {h_g0, h_g1}, (i % 2 == 0) ? 2'b10 : 2'b01);
        end
        m0_req = 0; m1_req = 0;
        tick();
        chk("tie_idle", {g0, g1, h_g0, h_g1}, 4'b0000);

        // 2: single read from address 3
        m0_req = 1; m0_addr = 16'd3; m0_wren_n = 1;
        chk("rd_arb", g0, 0);
        tick();
        chk("rd_gnt", g0, 1);
        chk("rd_addr", maddr, 16'd3);
        chk("rd_valid_early", v0, 0);
        tick();
        m0_req = 0;
        #1;
        chk("rd_data", d0, 16'h4000);
        chk("rd_valid", v0, 1);
        chk("rd_gnt_drop", g0, 0);
        tick();
        chk("rd_valid_clr", v0, 0);
        chk("rd_data_hold", d0, 16'h4000);

        // 5: port-1 write then drop, then confirm IDLE via tie resolution
        m1_req = 1; m1_addr = 16'h0010; m1_dout = 16'hBEEF; m1_wren_n = 0;
        tick();
        chk("w1_gnt", g1, 1);
        chk("w1_bus", {wr, maddr, mdout}, {1'b0, 16'h0010, 16'hBEEF});
        tick();
        m1_req = 0; m1_wren_n = 1; m1_addr = 0; m1_dout = 0;
        #1;
        chk("w1_valid", v1, 0);
        chk("w1_wren_off", {wr, g1}, 2'b10);
        tick();
        chk("w1_idle", {g0, g1, wr}, 3'b001);
        m0_req = 1; m1_req = 1;
        chk("w1_tie_arb", {g0, g1}, 2'b00);
        tick();
        chk("w1_tie_p0", {g0, g1}, 2'b10);
        m0_req = 0; m1_req = 0;
        tick();

        // 6: lone requester holds the bus, then hands over when port 0 arrives
        m1_req = 1; m1_addr = 16'h0044; m1_wren_n = 1;
        tick();
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("lone_%0d", i), {g0, g1}, 2'b01);
            if (i < 19) tick();
        end
        chk("lone_data", d1, 16'h0044 ^ 16'h5A5A);
        m0_req = 1; m0_addr = 16'h0007;
        #1;
        chk("lone_still1", {g0, g1}, 2'b01);
        tick();
        chk("handover", {g0, g1}, 2'b10);
        chk("handover_b1", {h_g0, h_g1}, 2'b10);
        m0_req = 0; m1_req = 0;
        tick();
        chk("end_idle", {g0, g1, wr}, 3'b001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    always @(negedge clk) begin
        if (rst_n && g0 && g1) begin
            n_tests++;
            n_fail++;
            $display("FAIL both_gnt: got 11 expected at most one");
        end
    end

    initial begin
        #50000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule
